// File: rtl/vinstru_mc_pkg.sv
// -----------------------------------------------------------------------------
// vinstru_mc_pkg
// Shared types and constants for the multi-channel pulse instrument:
//   sample_t   - signed 16-bit sample
//   state_t    - capture FSM states (IDLE / CAPTURE / DONE)
//   LFSR_SEED  - noise LFSR seed
//   LFSR_TAPS  - Galois tap mask for x^16 + x^14 + x^13 + x^11 + 1
//   saturate() - clamp a wide signed value to sample_t
// -----------------------------------------------------------------------------
package vinstru_mc_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Callers sign-extend their accumulator to 32 bits before clamping.
    function automatic sample_t saturate(input logic signed [31:0] value);
        if (value > 32'sd32767) begin
            return 16'sh7FFF;
        end else if (value < -32'sd32768) begin
            return 16'sh8000;
        end else begin
            return value[15:0];
        end
    endfunction

endpackage

// File: rtl/vinstru_mc_chan.sv
// -----------------------------------------------------------------------------
// vinstru_mc_chan
// One pulse-generator channel: a free-running 0..period-1 counter and a
// combinational output that equals the amplitude while count < width.
//   clk, reset  - clock, asynchronous active-high reset
//   clear       - hold the counter at zero (used outside of capture)
//   enable      - channel enable
//   period      - period in clk cycles (0 keeps the output at 0)
//   width       - high time in clk cycles
//   amplitude   - signed output level while high
//   sample      - channel output
// -----------------------------------------------------------------------------
module vinstru_mc_chan
    import vinstru_mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] period,
    input  logic [15:0] width,
    input  sample_t     amplitude,
    output sample_t     sample
);

    logic [31:0] count;

    // Using >= rather than == lets a shrinking period take effect on the
    // next count instead of running the counter out to 2**32.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear || (period == '0) || (count >= period - 32'd1)) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

    assign sample = (enable && (period != '0) && (count < {16'd0, width})) ? amplitude : '0;

endmodule

// File: rtl/vinstru_mc.sv
// -----------------------------------------------------------------------------
// vinstru_mc
// Multi-channel pulse instrument with capture buffer. NCH pulse channels are
// summed (plus optional LFSR noise), saturated to 16 bits, packed two samples
// per 32-bit word and written into a 2**DEPTH_LOG2-word simple dual-port RAM
// that the host reads back.
//   clk, reset        - single clock, asynchronous active-high reset
//   enable[NCH]       - per-channel enable
//   run               - level-sensitive capture request
//   done              - high while in DONE
//   pulse_period      - NCH x 32 period
//   pulse_width       - NCH x 16 high time
//   pulse_amplitude   - NCH x 16 signed amplitude
//   noise_amplitude   - unsigned noise scale (noise build only)
//   host_en/host_addr - host read strobe/address
//   host_rdata        - read data, one cycle after host_en, read-first
// Build option: define VINSTRU_MC_NOISE_EN to add the 16-bit Galois LFSR
// noise term; without it the noise term is 0 and no LFSR exists.
// -----------------------------------------------------------------------------
module vinstru_mc
    import vinstru_mc_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NCH-1:0]             enable,
    input  logic                       run,
    output logic                       done,
    input  logic [NCH-1:0][31:0]       pulse_period,
    input  logic [NCH-1:0][15:0]       pulse_width,
    input  logic [NCH-1:0][15:0]       pulse_amplitude,
    input  logic [15:0]                noise_amplitude,
    input  logic                       host_en,
    input  logic [DEPTH_LOG2-1:0]      host_addr,
    output logic [31:0]                host_rdata
);

    localparam int SUM_W = 16 + $clog2(NCH + 1);

    state_t                   state, state_nxt;
    logic [DEPTH_LOG2-1:0]    wr_addr;
    logic                     wr_en;
    sample_t                  chan_sample [NCH];
    sample_t                  noise;
    sample_t                  sample_sat;
    logic signed [SUM_W-1:0]  sum;
    sample_t                  smp_q;      // sample from the previous cycle
    sample_t                  even_q;     // even half of the word being built
    logic                     smp_vld;
    logic                     smp_odd;
    logic                     phase;      // parity of the sample computed now
    logic [31:0]              mem [2**DEPTH_LOG2];

    // Counters are held at zero outside CAPTURE, so every capture starts
    // with all channels at count 0.
    for (genvar g = 0; g < NCH; g++) begin : g_chan
        vinstru_mc_chan u_chan (
            .clk       (clk),
            .reset     (reset),
            .clear     (state != ST_CAPTURE),
            .enable    (enable[g]),
            .period    (pulse_period[g]),
            .width     (pulse_width[g]),
            .amplitude (sample_t'(pulse_amplitude[g])),
            .sample    (chan_sample[g])
        );
    end

`ifdef VINSTRU_MC_NOISE_EN
    logic [15:0]        lfsr;
    logic signed [32:0] noise_prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else if (state == ST_CAPTURE) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    // |lfsr * amp| / 2**16 always fits in 16 signed bits, so the cast only
    // drops redundant sign bits.
    assign noise_prod = $signed(lfsr) * $signed({1'b0, noise_amplitude});
    assign noise      = sample_t'(noise_prod >>> 16);
`else
    logic unused_noise_amplitude;
    assign unused_noise_amplitude = ^noise_amplitude;
    assign noise                  = '0;
`endif

    always_comb begin
        sum = SUM_W'(noise);
        for (int i = 0; i < NCH; i++) begin
            sum = sum + SUM_W'(chan_sample[i]);
        end
    end

    assign sample_sat = saturate(32'(sum));

    // A word is committed once its odd sample sits in smp_q; dropping run
    // stops writes immediately.
    assign wr_en = (state == ST_CAPTURE) && run && smp_vld && smp_odd;
    assign done  = (state == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt is given a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (run) state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else if (wr_en && (&wr_addr)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:    if (!run) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Outside CAPTURE the pipeline is emptied so stale samples from a
    // previous run never reach word 0 of the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_addr <= '0;
            smp_q   <= '0;
            even_q  <= '0;
            smp_vld <= 1'b0;
            smp_odd <= 1'b0;
            phase   <= 1'b0;
        end else if (state != ST_CAPTURE) begin
            wr_addr <= '0;
            smp_vld <= 1'b0;
            smp_odd <= 1'b0;
            phase   <= 1'b0;
        end else begin
            smp_q   <= sample_sat;
            smp_vld <= 1'b1;
            smp_odd <= phase;
            phase   <= ~phase;
            if (smp_vld && !smp_odd) begin
                even_q <= smp_q;
            end
            if (wr_en) begin
                wr_addr <= wr_addr + DEPTH_LOG2'(1);
            end
        end
    end

    // NOTE: the buffer has no reset so it maps onto block RAM and keeps its
    // contents across reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {smp_q, even_q};
        end
    end

    // Reading in a separate edge-triggered process returns the pre-write
    // word when host_addr == wr_addr (read-first).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_rdata <= '0;
        end else if (host_en) begin
            host_rdata <= mem[host_addr];
        end
    end

endmodule

// File: tb/tb_vinstru_mc.sv
// -----------------------------------------------------------------------------
// tb_vinstru_mc
// Directed bench for vinstru_mc (NCH=4, DEPTH_LOG2=4). Host reads push their
// expected word into a queue; a monitor pops and compares when read data is
// presented. Control checks (done, reset values) are made inline.
// -----------------------------------------------------------------------------
module tb_vinstru_mc;

    localparam int NCH      = 4;
    localparam int DL       = 4;
    localparam int NW       = 16;
    // posedges from the first CAPTURE edge to DONE: 2*NW + 2
    localparam int DONE_LAT = 34;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  run;
    logic                  done;
    logic [NCH-1:0]        enable;
    logic [NCH-1:0][31:0]  pulse_period;
    logic [NCH-1:0][15:0]  pulse_width;
    logic [NCH-1:0][15:0]  pulse_amplitude;
    logic [15:0]           noise_amplitude;
    logic                  host_en;
    logic [DL-1:0]         host_addr;
    logic [31:0]           host_rdata;

    vinstru_mc #(.NCH(NCH), .DEPTH_LOG2(DL)) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .run             (run),
        .done            (done),
        .pulse_period    (pulse_period),
        .pulse_width     (pulse_width),
        .pulse_amplitude (pulse_amplitude),
        .noise_amplitude (noise_amplitude),
        .host_en         (host_en),
        .host_addr       (host_addr),
        .host_rdata      (host_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t     exp_q [$];
    logic        rd_pend = 1'b0;
    logic [31:0] last_exp;
    logic [31:0] mixed [NW];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
        end
    endtask

    // Monitor: read data is valid on the cycle after host_en was sampled.
    always @(posedge clk) rd_pend <= host_en;

    always @(negedge clk) begin
        if (rd_pend) begin : mon
            rd_exp_t e;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got 0x%08h expected nothing queued", host_rdata);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("rd_word[%0d]", e.addr), host_rdata, e.data);
            end
        end
    end

    // Single-channel pattern sample k and packed word w.
    function automatic logic [15:0] pat(input int k, input int per, input int wid, input logic [15:0] amp);
        return ((k % per) < wid) ? amp : 16'h0000;
    endfunction

    function automatic logic [31:0] pat_word(input int w, input int per, input int wid, input logic [15:0] amp);
        return {pat(2*w+1, per, wid, amp), pat(2*w, per, wid, amp)};
    endfunction

    // Reference sum of the currently driven channel configuration.
    function automatic logic [15:0] model_sample(input int k);
        int acc = 0;
        for (int ch = 0; ch < NCH; ch++) begin
            if (enable[ch] && pulse_period[ch] != 0 &&
                (k % int'(pulse_period[ch])) < int'(pulse_width[ch])) begin
                acc += int'($signed(pulse_amplitude[ch]));
            end
        end
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return 16'(acc);
    endfunction

    task automatic set_single(input int per, input int wid, input logic [15:0] amp);
        enable = 4'b0001;
        pulse_period[0] = 32'(per); pulse_width[0] = 16'(wid); pulse_amplitude[0] = amp;
        for (int ch = 1; ch < NCH; ch++) begin
            // disabled channels carry a loud pattern that must not appear
            pulse_period[ch] = 32'd2; pulse_width[ch] = 16'd1; pulse_amplitude[ch] = 16'h7000;
        end
    endtask

    task automatic set_all(input int per, input int wid, input logic [15:0] amp);
        enable = '1;
        for (int ch = 0; ch < NCH; ch++) begin
            pulse_period[ch] = 32'(per); pulse_width[ch] = 16'(wid); pulse_amplitude[ch] = amp;
        end
    endtask

    task automatic capture_full(input string tag);
        int cyc  = 0;
        bit seen = 1'b0;
        @(posedge clk); #1; run = 1'b1;
        while (!seen && cyc < 200) begin
            @(posedge clk); cyc++;
            @(negedge clk); seen = done;
        end
        check({tag, "_done_latency"}, 32'(cyc), 32'(DONE_LAT));
        @(posedge clk); @(negedge clk);
        check({tag, "_done_hold"}, 32'(done), 32'd1);
        run = 1'b0;
        @(posedge clk); @(negedge clk);
        check({tag, "_done_fall"}, 32'(done), 32'd0);
    endtask

    task automatic rd(input int a, input logic [31:0] e);
        rd_exp_t item;
        @(posedge clk); #1;
        host_en   = 1'b1;
        host_addr = DL'(a);
        item.addr = a;
        item.data = e;
        exp_q.push_back(item);
        last_exp  = e;
    endtask

    task automatic rd_end();
        @(posedge clk); #1; host_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; host_en = 1'b0; host_addr = '0; enable = '0;
        pulse_period = '0; pulse_width = '0; pulse_amplitude = '0;
`ifdef VINSTRU_MC_NOISE_EN
        noise_amplitude = 16'h0000;
`else
        noise_amplitude = 16'hFFFF;  // must have no effect in this build
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rdata", host_rdata, 32'h0);

        // Single channel: 1000,1000,1000,0 x7 repeating
        set_single(10, 3, 16'h1000);
        capture_full("single");
        for (int w = 0; w < NW; w++) rd(w, pat_word(w, 10, 3, 16'h1000));
        rd_end();
        repeat (3) begin @(posedge clk); #1 host_addr = host_addr + 1'b1; end
        @(negedge clk);
        check("rdata_hold", host_rdata, last_exp);

        // Saturation, width >= period
        set_all(5, 7, 16'h7000);
        capture_full("sat_pos");
        rd(0, 32'h7FFF7FFF); rd(9, 32'h7FFF7FFF); rd(15, 32'h7FFF7FFF);
        rd_end();
        set_all(5, 7, 16'h9000);
        capture_full("sat_neg");
        rd(0, 32'h80008000); rd(15, 32'h80008000);
        rd_end();

        // Mixed: period 0 channel, positive and negative channels, one disabled
        enable = 4'b0111;
        pulse_period[0] = 32'd0; pulse_width[0] = 16'd3; pulse_amplitude[0] = 16'h1000;
        pulse_period[1] = 32'd4; pulse_width[1] = 16'd1; pulse_amplitude[1] = 16'h0100;
        pulse_period[2] = 32'd3; pulse_width[2] = 16'd2; pulse_amplitude[2] = 16'hFFF0;
        pulse_period[3] = 32'd2; pulse_width[3] = 16'd1; pulse_amplitude[3] = 16'h7000;
        capture_full("mixed");
        for (int w = 0; w < NW; w++) mixed[w] = {model_sample(2*w+1), model_sample(2*w)};
        check("mixed_word0_hand", mixed[0], 32'hFFF000F0);
        for (int w = 0; w < NW; w++) rd(w, mixed[w]);
        rd_end();

        // Abort after word 4 has been written (edge 12 of the capture)
        set_single(10, 3, 16'h0200);
        @(posedge clk); #1 run = 1'b1;
        repeat (12) @(posedge clk);
        #1 run = 1'b0;
        @(negedge clk);
        check("abort_done", 32'(done), 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("abort_done_stays", 32'(done), 32'd0);
        for (int w = 0; w < NW; w++) rd(w, (w < 5) ? pat_word(w, 10, 3, 16'h0200) : mixed[w]);
        rd_end();

        // Reset mid-capture after word 1 is written
        set_single(4, 2, 16'h0300);
        @(posedge clk); #1 run = 1'b1;
        repeat (6) @(posedge clk);
        #1 reset = 1'b1; run = 1'b0;
        @(negedge clk);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_rdata", host_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rd(0, 32'h03000300); rd(1, 32'h00000000); rd(2, 32'h00000000);
        rd_end();

        // Restart after reset begins at word 0
        set_single(4, 2, 16'h0400);
        capture_full("restart");
        rd(0, 32'h04000400); rd(14, 32'h04000400); rd(15, 32'h00000000);
        rd_end();

`ifdef VINSTRU_MC_NOISE_EN
        begin : noise_test
            logic [15:0] l;
            logic [15:0] ns [8];
            @(posedge clk); #1 reset = 1'b1;
            @(posedge clk); #1 reset = 1'b0;
            enable = '0;
            noise_amplitude = 16'hFFFF;
            l = 16'hACE1;
            for (int k = 0; k < 8; k++) begin
                ns[k] = 16'((longint'($signed(l)) * 65535) >>> 16);
                l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
            end
            capture_full("noise");
            for (int w = 0; w < 4; w++) rd(w, {ns[2*w+1], ns[2*w]});
            rd_end();
            noise_amplitude = 16'h0000;
        end
`endif

        begin : drain
            int guard = 0;
            while (exp_q.size() != 0 && guard < 20) begin
                @(negedge clk); guard++;
            end
            @(negedge clk);
            if (exp_q.size() != 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_drain: got %0d pending reads expected 0", exp_q.size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/vinstru_mc.md
VINSTRU_MC -- requirements
Module: vinstru_mc

Interface
REQ-001 Parameter NCH, default 4: number of pulse-generator channels, range 1..8.
REQ-002 Parameter DEPTH_LOG2, default 12: capture buffer depth in 32-bit words (2**DEPTH_LOG2 words).
REQ-003 Port clk  input  1: single clock for all logic, including the host read port.
REQ-004 Port reset  input  1: asynchronous, active-high reset.
REQ-005 Port enable  input  NCH: per-channel pulse enable.
REQ-006 Port run  input  1: capture request, level-sensitive.
REQ-007 Port done  output  1: capture complete.
REQ-008 Port pulse_period  input  NCH x 32: per-channel period, in clk cycles.
REQ-009 Port pulse_width  input  NCH x 16: per-channel high time, in clk cycles.
REQ-010 Port pulse_amplitude  input  NCH x 16: per-channel signed amplitude.
REQ-011 Port noise_amplitude  input  16: unsigned noise scale.
REQ-012 Port host_en  input  1: host read strobe.
REQ-013 Port host_addr  input  DEPTH_LOG2: host word address.
REQ-014 Port host_rdata  output  32: host read data.

Function
REQ-015 The FSM shall have states IDLE, CAPTURE and DONE.
REQ-016 IDLE->CAPTURE shall occur on the first cycle run=1 is seen while in IDLE; write address and all channel counters shall clear on entry.
REQ-017 Each channel counter shall count 0..period-1 and wrap; channel output = amplitude when count<width and enable=1, else 0.
REQ-018 pulse_period=0 shall hold the channel output at 0; width>=period shall give constant amplitude.
REQ-019 Period, width and amplitude shall be sampled every cycle; a change shall take effect on the next count, with no restart of the counter.
REQ-020 The sum of all channel outputs plus noise shall be computed at 16+clog2(NCH+1) bits signed and saturated to signed 16 bits (0x7FFF / 0x8000).
REQ-021 Samples shall be packed two per word: even sample in bits [15:0], odd sample in bits [31:16]; one word shall be written every second CAPTURE cycle.
REQ-022 Sample-to-buffer latency shall be fixed at 2 cycles; the pipeline shall be flushed so that word 0 holds samples 0 and 1 after the channel counters clear.
REQ-023 CAPTURE->DONE shall occur when word 2**DEPTH_LOG2-1 is written, with no wrap-around; done shall be 1 in DONE only.
REQ-024 DONE->IDLE shall occur when run=0; done shall drop the same cycle.
REQ-025 If run drops during CAPTURE, the block shall go to IDLE with done=0; words already written shall stay valid and the remaining words shall keep their old data.
REQ-026 host_rdata shall return the word at host_addr one cycle after host_en=1, and shall hold its value while host_en=0.
REQ-027 A host read of the address being written in the same cycle shall return the old data (read-first).

Reset
REQ-028 Reset shall force the state to IDLE, done=0, channel counters=0, the write address=0, the LFSR to its seed and host_rdata=0.
REQ-029 Reset shall not clear buffer contents.
REQ-030 Reset asserted mid-capture shall abort without any further buffer write.

Configuration
REQ-031 With VINSTRU_MC_NOISE_EN defined, the noise term shall be a 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, seed 0xACE1, stepping every CAPTURE cycle.
REQ-032 With VINSTRU_MC_NOISE_EN defined, noise = (signed LFSR x noise_amplitude) >>> 16.
REQ-033 Without VINSTRU_MC_NOISE_EN, the noise term shall be constant 0, noise_amplitude shall be ignored and no LFSR shall be built.

Structure
REQ-034 Package vinstru_mc_pkg shall hold: sample_t (signed 16), the state enum, LFSR_SEED, LFSR_TAPS, and a saturate function.
REQ-035 One sub-module, vinstru_mc_chan, shall implement a single channel counter and output, instantiated NCH times by a generate loop.
REQ-036 The buffer shall be an inferred simple dual-port RAM, 32 x 2**DEPTH_LOG2.

Verification
REQ-037 Single channel: NCH=1, period=10, width=3, amp=0x1000, noise off -> the sample stream repeats 1000,1000,1000,0 x7.
REQ-038 Saturation: 4 channels each with amp=0x7000, width>=period -> every sample = 0x7FFF; with each amp=0x9000 -> every sample = 0x8000.
REQ-039 Handshake: DEPTH_LOG2=4, run=1 -> done rises after the write of word 15 and falls on run=0; host read of addr 0 returns {s1,s0}.
REQ-040 Abort: run dropped after 5 words written -> state IDLE, done stays 0, words 5..15 unchanged.
REQ-041 Noise: VINSTRU_MC_NOISE_EN defined, noise_amplitude=0xFFFF, all channels disabled -> the first samples match the reference LFSR model from seed 0xACE1.
REQ-042 Reset: reset pulsed mid-capture -> done=0, host_rdata=0, and a following run restarts at word 0.
